// File: rtl/mem_unit.sv
// Word-addressed memory slave for the CPU memory port. It captures one request, waits
// LATENCY cycles, accesses the word array, and returns a one-cycle ready pulse (with a fault flag).
module mem_unit #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        mem_enable,
    input  logic        read_or_write,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        mem_fault
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

    state_t                state;
    logic [3:0]            count;
    logic [31:0]           addr_cap;
    logic [31:0]           wdata_cap;
    logic                  write_cap;
    logic [31:0]           mem [DEPTH];

    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic                  acc_write;
    logic                  acc_fault;
    logic [DEPTH_LOG2-1:0] acc_index;
    logic                  enter_resp;

    // With LATENCY=1 the access happens on the acceptance edge, so the live inputs
    // are used there; otherwise the copies captured at acceptance are used.
    always_comb begin
        if (state == IDLE) begin
            acc_addr  = addr;
            acc_wdata = write_data;
            acc_write = read_or_write;
        end else begin
            acc_addr  = addr_cap;
            acc_wdata = wdata_cap;
            acc_write = write_cap;
        end
        acc_index  = acc_addr[DEPTH_LOG2+1:2];
        acc_fault  = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
        enter_resp = ((state == IDLE) && mem_enable && (LATENCY == 1))
                  || ((state == BUSY) && (count == 4'd1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            addr_cap  <= 32'd0;
            wdata_cap <= 32'd0;
            write_cap <= 1'b0;
            read_data <= 32'd0;
            mem_ready <= 1'b0;
            mem_fault <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_enable) begin
                        addr_cap  <= addr;
                        wdata_cap <= write_data;
                        write_cap <= read_or_write;
                        count     <= WAIT_INIT;
                        state     <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= RESP;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (enter_resp) begin
                mem_ready <= 1'b1;
                mem_fault <= acc_fault;
                if (!acc_fault && !acc_write) begin
                    read_data <= mem[acc_index];
                end
            end
        end
    end

    // The array is never reset; a reset held across an edge must still block the write.
    always_ff @(posedge clock) begin
        if (!reset && enter_resp && acc_write && !acc_fault) begin
            mem[acc_index] <= acc_wdata;
        end
    end
endmodule

// File: tb/tb_mem_unit.sv
// Randomized self-checking bench for mem_unit: a word-array model predicts the ready
// timing, fault flag, and read data of every access.
module tb_mem_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'd0, write_data = 32'd0;
    logic        mem_enable = 1'b0, read_or_write = 1'b0;
    logic [31:0] read_data;
    logic        mem_ready, mem_fault;

    logic [31:0] addr1 = 32'd0, write_data1 = 32'd0;
    logic        mem_enable1 = 1'b0, read_or_write1 = 1'b0;
    logic [31:0] read_data1;
    logic        mem_ready1, mem_fault1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [1024];
    logic [31:0] exp_rd = 32'd0;

    mem_unit #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
        .clock(clock), .reset(reset), .addr(addr), .write_data(write_data),
        .mem_enable(mem_enable), .read_or_write(read_or_write),
        .read_data(read_data), .mem_ready(mem_ready), .mem_fault(mem_fault)
    );

    mem_unit #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .addr(addr1), .write_data(write_data1),
        .mem_enable(mem_enable1), .read_or_write(read_or_write1),
        .read_data(read_data1), .mem_ready(mem_ready1), .mem_fault(mem_fault1)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the first idle
    // cycle after the response, so back-to-back calls run at the maximum request rate.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic rw,
                          input bit scramble);
        logic       exp_fault;
        logic [9:0] idx;
        exp_fault = (a[1:0] != 2'b00) || (a >= 32'h1000);
        idx = a[11:2];
        addr = a; write_data = wd; read_or_write = rw; mem_enable = 1'b1;
        @(negedge clock);
        check("busy_ready", 32'(mem_ready), 32'd0);
        mem_enable = 1'b0;
        if (scramble) begin
            addr = $urandom; write_data = $urandom; read_or_write = ~rw;
            mem_enable = 1'($urandom_range(0, 1));
        end
        @(negedge clock);
        if (!exp_fault) begin
            if (rw) model_mem[idx] = wd;
            else exp_rd = model_mem[idx];
        end
        check("ready", 32'(mem_ready), 32'd1);
        check("fault", 32'(mem_fault), 32'(exp_fault));
        check("read_data", read_data, exp_rd);
        $display("%s addr=%h wdata=%h fault=%0d read_data=%h", rw ? "WR" : "RD", a, wd,
                 mem_fault, read_data);
        @(negedge clock);
        mem_enable = 1'b0;
        check("ready_drop", 32'(mem_ready), 32'd0);
        check("fault_drop", 32'(mem_fault), 32'd0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_fault", 32'(mem_fault), 32'd0);
        check("rst_rdata", read_data, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Directed: write then read, faults leave read_data and word 0 alone
        access(32'h0000_0000, 32'h1111_2222, 1'b1, 1'b0);
        access(32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
        access(32'h0000_0010, 32'h0, 1'b0, 1'b0);
        access(32'h0000_0012, 32'h0, 1'b0, 1'b1);
        access(32'h0000_1000, 32'hBAD0_BAD0, 1'b1, 1'b1);
        access(32'h0000_0000, 32'h0, 1'b0, 1'b0);
        access(32'h0000_0020, 32'hCAFE_F00D, 1'b1, 1'b1);

        // Fill the remaining words the random phase reads from
        for (int k = 0; k < 16; k++) begin
            if (k != 0 && k != 4 && k != 8) access(32'(k * 4), $urandom, 1'b1, 1'b0);
        end

        // Reset mid-BUSY of a write: the write must not land
        addr = 32'h20; write_data = 32'h1234_5678; read_or_write = 1'b1; mem_enable = 1'b1;
        @(negedge clock);
        mem_enable = 1'b0;
        reset = 1'b1;
        #1;
        check("busy_rst_ready", 32'(mem_ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_rd = 32'd0;
        @(negedge clock);
        access(32'h0000_0020, 32'h0, 1'b0, 1'b0);

        // Reset asserted mid-cycle during the ready cycle
        addr = 32'h10; read_or_write = 1'b0; mem_enable = 1'b1;
        @(negedge clock);
        mem_enable = 1'b0;
        @(negedge clock);
        check("resp_ready", 32'(mem_ready), 32'd1);
        check("resp_rdata", read_data, 32'hDEAD_BEEF);
        #2 reset = 1'b1;
        #1;
        check("async_rst_ready", 32'(mem_ready), 32'd0);
        check("async_rst_fault", 32'(mem_fault), 32'd0);
        check("async_rst_rdata", read_data, 32'd0);
        exp_rd = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Random traffic: reads/writes of known words, misaligned and out-of-range accesses
        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            case (kind)
                0: a = 32'($urandom_range(0, 15) * 4);
                1: a = 32'($urandom_range(0, 15) * 4);
                2: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                default: a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
            endcase
            access(a, $urandom, (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        // Held enable with LATENCY=1: a pulse every second cycle, each a separate write
        read_or_write1 = 1'b1; addr1 = 32'h40; mem_enable1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("held_ready", 32'(mem_ready1), 32'(i % 2));
            check("held_fault", 32'(mem_fault1), 32'd0);
            write_data1 = 32'(100 + i);
            @(negedge clock);
        end
        check("held_ready_end", 32'(mem_ready1), 32'd0);
        read_or_write1 = 1'b0;
        @(negedge clock);
        mem_enable1 = 1'b0;
        check("held_rd_ready", 32'(mem_ready1), 32'd1);
        check("held_rd_data", read_data1, 32'd108);
        $display("HELD last write readback=%0d", read_data1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
